// File: rtl/tse_ctrl_pkg.sv
// Purpose : shared constants for the TSE MAC bring-up controller (CSR word offsets,
//           command_config bit positions, PHY status bits, speed encoding, FSM states).
// Ports   : none (package). Latency / backpressure: not applicable.
package tse_ctrl_pkg;

    // TSE CSR word offsets; 0x80+ is the MDIO space window onto PHY registers
    localparam logic [7:0] REG_CMD_CONFIG = 8'h02;
    localparam logic [7:0] REG_MAC0       = 8'h03;
    localparam logic [7:0] REG_MAC1       = 8'h04;
    localparam logic [7:0] REG_FRM_LENGTH = 8'h05;
    localparam logic [7:0] REG_MDIO_ADDR0 = 8'h0F;
    localparam logic [7:0] REG_PHY_STATUS = 8'h81;
    localparam logic [7:0] REG_PHY_SPEC   = 8'h91;

    // command_config bit positions
    localparam int CMD_TX_ENA    = 0;
    localparam int CMD_RX_ENA    = 1;
    localparam int CMD_ETH_SPEED = 3;
    localparam int CMD_SW_RESET  = 13;
    localparam int CMD_ENA_10    = 25;

    localparam logic [31:0] CMD_SW_RESET_VAL = 32'd1 << CMD_SW_RESET;

    // PHY register bits
    localparam int PHY_LINK_BIT     = 2;   // reg 1: link status
    localparam int PHY_RESOLVED_BIT = 11;  // reg 17: speed/duplex resolved

    // Encoding matches PHY reg 17 bits [15:14]
    typedef enum logic [1:0] {
        SPD_10   = 2'b00,
        SPD_100  = 2'b01,
        SPD_1000 = 2'b10,
        SPD_BAD  = 2'b11
    } speed_t;

    typedef enum logic [3:0] {
        IDLE,
        SWRST,
        SWRST_POLL,
        MAC0,
        MAC1,
        FRMLEN,
        MDIOADDR,
        LINK_POLL,
        SPEED,
        ENABLE,
        RUN,
        WAIT,
        ERR
    } state_t;

    // command_config value that enables the datapath at the given speed
    function automatic logic [31:0] cmd_enable_word(input speed_t spd);
        logic [31:0] w;
        w = (32'd1 << CMD_TX_ENA) | (32'd1 << CMD_RX_ENA);
        if (spd == SPD_1000) w = w | (32'd1 << CMD_ETH_SPEED);
        if (spd == SPD_10)   w = w | (32'd1 << CMD_ENA_10);
        return w;
    endfunction

endpackage

// File: rtl/tse_avm_xact.sv
// Purpose : single Avalon-MM transfer engine; one req (held until ack) -> one read or write.
// Latency : bus asserted the cycle after req, ack one cycle after the waitrequest=0 cycle.
// Backpr. : holds address/read/write/writedata stable while avm_waitrequest=1.
// Ports   : req/wr/addr/wdata from the sequencer, ack/rdata back; avm_* to the CSR slave.
module tse_avm_xact (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic [31:0] rdata,
    output logic [7:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avm_address   <= 8'h00;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            avm_writedata <= 32'h0;
            ack           <= 1'b0;
            rdata         <= 32'h0;
        end else begin
            ack <= 1'b0;
            if (avm_read || avm_write) begin
                if (!avm_waitrequest) begin
                    avm_read  <= 1'b0;
                    avm_write <= 1'b0;
                    ack       <= 1'b1;
                    rdata     <= avm_readdata;
                end
            end else if (req && !ack) begin
                // req is still high during the ack cycle; !ack prevents a duplicate launch
                avm_read      <= !wr;
                avm_write     <= wr;
                avm_address   <= addr;
                avm_writedata <= wdata;
            end
        end
    end

endmodule

// File: rtl/tse_mac_init_ctrl.sv
// Purpose : brings up an Altera TSE MAC: SW reset, station address, frame length, PHY
//           address, waits for link, resolves speed, enables TX/RX, then monitors link.
// Latency : three cycles per zero-wait CSR transfer (request, bus, acknowledge).
// Backpr. : follows avm_waitrequest; start while busy is deferred to the end of the
//           current transfer. Ports: clk_clk/reset_reset, start+mac_addr, avm_* master,
//           set_1000/set_10 to the MAC, busy/link_up/done/error status.
module tse_mac_init_ctrl
    import tse_ctrl_pkg::*;
#(
    parameter logic [4:0] PHY_ADDR      = 5'd0,
    parameter int         POLL_INTERVAL = 1_000_000,
    parameter int         RST_TIMEOUT   = 1024,
    parameter int         FRM_LEN       = 1518
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    input  logic        start,
    input  logic [47:0] mac_addr,
    output logic [7:0]  avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        set_1000,
    output logic        set_10,
    output logic        busy,
    output logic        link_up,
    output logic        done,
    output logic        error
);

    state_t      state, state_nxt;
    logic        req, wr, ack;
    logic [7:0]  addr;
    logic [31:0] wdata, rdata;

    logic [47:0] mac_q;
    logic [31:0] rd_cnt, poll_cnt;
    speed_t      speed_q, spd_nxt;
    logic        restart_pend, link_lost;

    logic        go_rst, rd_inc, load_poll, dec_poll, spd_ld;
    logic        enable_done, lost_set, lost_clr, xfer_state;

    logic        unused_rdata;
    assign unused_rdata = &{1'b0, rdata[31:16], rdata[12], rdata[10:3], rdata[1:0]};

    tse_avm_xact u_xact (
        .clk             (clk_clk),
        .rst             (reset_reset),
        .req             (req),
        .wr              (wr),
        .addr            (addr),
        .wdata           (wdata),
        .ack             (ack),
        .rdata           (rdata),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    assign busy  = !(state inside {IDLE, RUN, WAIT, ERR});
    assign error = (state == ERR);

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) state <= IDLE;
        else             state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        req         = 1'b0;
        wr          = 1'b0;
        addr        = 8'h00;
        wdata       = 32'h0;
        go_rst      = 1'b0;
        rd_inc      = 1'b0;
        load_poll   = 1'b0;
        dec_poll    = 1'b0;
        spd_ld      = 1'b0;
        spd_nxt     = speed_q;
        enable_done = 1'b0;
        lost_set    = 1'b0;
        lost_clr    = 1'b0;
        // a request is outstanding (or about to launch) in these states, so a restart
        // must wait for its ack or the ack would be credited to the wrong state
        xfer_state  = busy || ((state == WAIT) && (link_lost || (poll_cnt == 32'd0)));

        case (state)
            IDLE: if (start) go_rst = 1'b1;
            SWRST: begin
                req = 1'b1; wr = 1'b1; addr = REG_CMD_CONFIG; wdata = CMD_SW_RESET_VAL;
                if (ack) state_nxt = SWRST_POLL;
            end
            SWRST_POLL: begin
                req = 1'b1; addr = REG_CMD_CONFIG;
                if (ack) begin
                    if (!rdata[CMD_SW_RESET])                  state_nxt = MAC0;
                    else if (rd_cnt == 32'(RST_TIMEOUT - 1))   state_nxt = ERR;
                    else                                       rd_inc = 1'b1;
                end
            end
            MAC0: begin
                req = 1'b1; wr = 1'b1; addr = REG_MAC0;
                wdata = {mac_q[23:16], mac_q[31:24], mac_q[39:32], mac_q[47:40]};
                if (ack) state_nxt = MAC1;
            end
            MAC1: begin
                req = 1'b1; wr = 1'b1; addr = REG_MAC1;
                wdata = {16'h0, mac_q[7:0], mac_q[15:8]};
                if (ack) state_nxt = FRMLEN;
            end
            FRMLEN: begin
                req = 1'b1; wr = 1'b1; addr = REG_FRM_LENGTH; wdata = 32'(FRM_LEN);
                if (ack) state_nxt = MDIOADDR;
            end
            MDIOADDR: begin
                req = 1'b1; wr = 1'b1; addr = REG_MDIO_ADDR0; wdata = {27'h0, PHY_ADDR};
                if (ack) state_nxt = LINK_POLL;
            end
            LINK_POLL: begin
                req = 1'b1; addr = REG_PHY_STATUS;
                if (ack && rdata[PHY_LINK_BIT]) state_nxt = SPEED;
            end
            SPEED: begin
                req = 1'b1; addr = REG_PHY_SPEC;
                if (ack && rdata[PHY_RESOLVED_BIT]) begin
                    spd_nxt = speed_t'(rdata[15:14]);
                    spd_ld  = 1'b1;
                    state_nxt = (spd_nxt == SPD_BAD) ? ERR : ENABLE;
                end
            end
            ENABLE: begin
                req = 1'b1; wr = 1'b1; addr = REG_CMD_CONFIG; wdata = cmd_enable_word(speed_q);
                if (ack) begin
                    enable_done = 1'b1;
                    state_nxt   = RUN;
                end
            end
            RUN: begin
                if (start) go_rst = 1'b1;
                else begin
                    load_poll = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (link_lost) begin
                    // link dropped: disable TX/RX before hunting for link again
                    req = 1'b1; wr = 1'b1; addr = REG_CMD_CONFIG; wdata = 32'h0;
                    if (ack) begin
                        lost_clr  = 1'b1;
                        state_nxt = LINK_POLL;
                    end
                end else if (poll_cnt != 32'd0) begin
                    dec_poll = 1'b1;
                    if (start) go_rst = 1'b1;
                end else begin
                    req = 1'b1; addr = REG_PHY_STATUS;
                    if (ack) begin
                        if (rdata[PHY_LINK_BIT]) state_nxt = RUN;
                        else                     lost_set  = 1'b1;
                    end
                end
            end
            ERR: if (start) go_rst = 1'b1;
            default: state_nxt = IDLE;
        endcase

        if (xfer_state && ack && (start || restart_pend)) go_rst = 1'b1;
        if (go_rst) state_nxt = SWRST;
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            mac_q        <= 48'h0;
            rd_cnt       <= 32'h0;
            poll_cnt     <= 32'h0;
            speed_q      <= SPD_10;
            restart_pend <= 1'b0;
            link_lost    <= 1'b0;
            set_1000     <= 1'b0;
            set_10       <= 1'b0;
            link_up      <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (start) mac_q <= mac_addr;
            restart_pend <= go_rst ? 1'b0 : (restart_pend | start);
            if (go_rst) begin
                rd_cnt    <= 32'h0;
                link_up   <= 1'b0;
                done      <= 1'b0;
                link_lost <= 1'b0;
            end else begin
                if (rd_inc) rd_cnt <= rd_cnt + 32'd1;
                if (load_poll)     poll_cnt <= 32'(POLL_INTERVAL - 1);
                else if (dec_poll) poll_cnt <= poll_cnt - 32'd1;
                if (spd_ld) speed_q <= spd_nxt;
                if (enable_done) begin
                    set_1000 <= (speed_q == SPD_1000);
                    set_10   <= (speed_q == SPD_10);
                    link_up  <= 1'b1;
                    done     <= 1'b1;
                end
                if (lost_set) begin
                    link_lost <= 1'b1;
                    link_up   <= 1'b0;
                    done      <= 1'b0;
                end
                if (lost_clr) link_lost <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tse_mac_init_ctrl.sv
// Purpose : directed bench for tse_mac_init_ctrl with a behavioural TSE CSR/PHY slave.
// Latency : n/a (bench).
// Backpr. : slave inserts a programmable number of waitrequest cycles per transfer.
module tb_tse_mac_init_ctrl;

    localparam int POLL = 16;
    localparam int RTO  = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [47:0] mac_addr = 48'h0;
    logic [7:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata, avm_readdata;
    logic        avm_waitrequest;
    logic        set_1000, set_10, busy, link_up, done, error;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tse_mac_init_ctrl #(
        .PHY_ADDR(5'd0), .POLL_INTERVAL(POLL), .RST_TIMEOUT(RTO), .FRM_LEN(1518)
    ) dut (
        .clk_clk(clk), .reset_reset(reset), .start(start), .mac_addr(mac_addr),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest),
        .set_1000(set_1000), .set_10(set_10), .busy(busy), .link_up(link_up),
        .done(done), .error(error)
    );

    // ---------------- behavioural slave ----------------
    int          ws = 0;            // waitrequest cycles per transfer
    int          clear_after = 1;   // SW_RESET reads that still show bit13=1
    logic        link = 1'b1;
    logic [31:0] reg17 = 32'h0000_A800;

    int          wcnt = 0, hold = 0, rd_since = 0;
    logic [7:0]  wr_addr [256];
    logic [31:0] wr_data [256];
    int          wr_n = 0, rd02_n = 0, rd81_n = 0;
    int          hold_bad = 0, stab_err = 0, proto_err = 0;
    logic [7:0]  p_addr;
    logic [31:0] p_wdata;
    logic        p_rd, p_wr, p_wait = 1'b0;

    assign avm_waitrequest = (avm_read || avm_write) && (wcnt < ws);

    always_comb begin
        avm_readdata = 32'h0;
        case (avm_address)
            8'h02: avm_readdata = (rd_since < clear_after) ? 32'h0000_2000 : 32'h0;
            8'h81: avm_readdata = {29'h0, link, 2'b00};
            8'h91: avm_readdata = reg17;
            default: avm_readdata = 32'h0;
        endcase
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt   <= 0;
            hold   <= 0;
            p_wait <= 1'b0;
        end else begin
            p_wait  <= avm_waitrequest;
            p_addr  <= avm_address;
            p_wdata <= avm_writedata;
            p_rd    <= avm_read;
            p_wr    <= avm_write;
            if (avm_read && avm_write) proto_err <= proto_err + 1;
            if (p_wait && ({avm_read, avm_write, avm_address, avm_writedata} !==
                           {p_rd, p_wr, p_addr, p_wdata}))
                stab_err <= stab_err + 1;
            if (avm_read || avm_write) begin
                if (avm_waitrequest) begin
                    wcnt <= wcnt + 1;
                    hold <= hold + 1;
                end else begin
                    wcnt <= 0;
                    hold <= 0;
                    if (hold + 1 != ws + 1) hold_bad <= hold_bad + 1;
                    if (avm_write) begin
                        wr_addr[wr_n[7:0]] <= avm_address;
                        wr_data[wr_n[7:0]] <= avm_writedata;
                        wr_n <= wr_n + 1;
                        if (avm_address == 8'h02 && avm_writedata == 32'h0000_2000)
                            rd_since <= 0;
                    end else begin
                        if (avm_address == 8'h02) begin
                            rd02_n   <= rd02_n + 1;
                            rd_since <= rd_since + 1;
                        end
                        if (avm_address == 8'h81) rd81_n <= rd81_n + 1;
                    end
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic pulse_start(input logic [47:0] mac);
        @(negedge clk);
        mac_addr = mac;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        mac_addr = 48'h0;   // must have been sampled on the start cycle
    endtask

    task automatic bus_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!avm_read && !avm_write) break;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({avm_read, avm_write, avm_address, avm_writedata} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_bus: got rd=%b wr=%b addr=%h wd=%h required all 0",
                     avm_read, avm_write, avm_address, avm_writedata);
        end
        vectors++;
        if ({set_1000, set_10, busy, link_up, done, error} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_status: got %b required 000000",
                     {set_1000, set_10, busy, link_up, done, error});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, avm_read, avm_write} !== 3'b000) begin
            miscompares++;
            $display("FAIL idle_no_start: got busy/rd/wr=%b required 000",
                     {busy, avm_read, avm_write});
        end
    endtask

    task automatic test_bringup_1000();
        int  base, rbase, hbase, sbase;
        bit  ok;
        logic [7:0]  ea [6];
        logic [31:0] ed [6];
        ea = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h0F, 8'h02};
        ed = '{32'h2000, 32'h17231C00, 32'h0000CB4A, 32'h5EE, 32'h0, 32'h0000000B};
        ws = 0; clear_after = 1; link = 1'b1; reg17 = 32'h0000_A800;
        base = wr_n; rbase = rd02_n; hbase = hold_bad; sbase = proto_err;
        pulse_start(48'h001C23174ACB);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_start: got %b required 1", busy);
        end
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL bringup_done: done never rose");
        end
        vectors++;
        if (wr_n - base !== 6) begin
            miscompares++;
            $display("FAIL bringup_nwrites: got %0d required 6", wr_n - base);
        end
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (wr_addr[8'(base + i)] !== ea[i] || wr_data[8'(base + i)] !== ed[i]) begin
                miscompares++;
                $display("FAIL bringup_write%0d: got %h=%h required %h=%h", i,
                         wr_addr[8'(base + i)], wr_data[8'(base + i)], ea[i], ed[i]);
            end
        end
        vectors++;
        if (rd02_n - rbase !== 2) begin
            miscompares++;
            $display("FAIL swrst_reads: got %0d required 2", rd02_n - rbase);
        end
        vectors++;
        if ({set_1000, set_10, link_up, busy, error} !== 5'b10100) begin
            miscompares++;
            $display("FAIL bringup_status: got s1000/s10/link/busy/err=%b required 10100",
                     {set_1000, set_10, link_up, busy, error});
        end
        vectors++;
        if (hold_bad != hbase || proto_err != sbase) begin
            miscompares++;
            $display("FAIL zero_wait_hold: got bad_holds=%0d rd_wr_both=%0d required 0 0",
                     hold_bad - hbase, proto_err - sbase);
        end
    endtask

    task automatic test_waitstates();
        int  base, hbase, sbase;
        bit  ok;
        ws = 3;
        bus_idle();
        base = wr_n; hbase = hold_bad; sbase = stab_err;
        pulse_start(48'h001C23174ACB);
        ok = 0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done) begin ok = 1; break; end
        end
        vectors++;
        if (!ok || wr_n - base !== 6) begin
            miscompares++;
            $display("FAIL ws_done: done=%b writes=%0d required 1 and 6", done, wr_n - base);
        end
        vectors++;
        if (wr_data[8'(base + 1)] !== 32'h17231C00 || wr_data[8'(base + 5)] !== 32'h0B) begin
            miscompares++;
            $display("FAIL ws_data: got mac0=%h enable=%h required 17231c00 0000000b",
                     wr_data[8'(base + 1)], wr_data[8'(base + 5)]);
        end
        vectors++;
        if (hold_bad != hbase || stab_err != sbase) begin
            miscompares++;
            $display("FAIL ws_hold: got wrong_len=%0d unstable=%0d required 0 0",
                     hold_bad - hbase, stab_err - sbase);
        end
    endtask

    task automatic test_back_to_back();
        int  base;
        bit  ok;
        ws = 0;
        bus_idle();
        base = wr_n;
        pulse_start(48'h001C23174ACB);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (avm_write && avm_address == 8'h05) begin ok = 1; break; end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        vectors++;
        if (!ok || !done || wr_n - base !== 10) begin
            miscompares++;
            $display("FAIL restart_count: done=%b writes=%0d required 1 and 10", done, wr_n - base);
        end
        vectors++;
        if (wr_addr[8'(base + 3)] !== 8'h05 || wr_addr[8'(base + 4)] !== 8'h02 ||
            wr_data[8'(base + 4)] !== 32'h2000) begin
            miscompares++;
            $display("FAIL restart_order: got %h then %h=%h required 05 then 02=00002000",
                     wr_addr[8'(base + 3)], wr_addr[8'(base + 4)], wr_data[8'(base + 4)]);
        end
    endtask

    task automatic test_timeout();
        int  rbase;
        bit  ok;
        clear_after = 1_000_000;
        bus_idle();
        rbase = rd02_n;
        pulse_start(48'h001C23174ACB);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (error) begin ok = 1; break; end
        end
        vectors++;
        if (!ok || rd02_n - rbase !== RTO) begin
            miscompares++;
            $display("FAIL timeout_reads: error=%b reads=%0d required 1 and %0d",
                     error, rd02_n - rbase, RTO);
        end
        rbase = rd02_n;
        repeat (20) @(negedge clk);
        vectors++;
        if ({error, busy, done, avm_read, avm_write} !== 5'b10000 || rd02_n != rbase) begin
            miscompares++;
            $display("FAIL err_idle: got err/busy/done/rd/wr=%b extra_reads=%0d required 10000 0",
                     {error, busy, done, avm_read, avm_write}, rd02_n - rbase);
        end
        clear_after = 1;
    endtask

    task automatic test_10m_linkdrop();
        int  r81;
        bit  ok;
        reg17 = 32'h0000_0800;
        pulse_start(48'h001C23174ACB);
        vectors++;
        if (error !== 1'b0) begin
            miscompares++;
            $display("FAIL err_cleared_by_start: got %b required 0", error);
        end
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        vectors++;
        if (!done || wr_addr[8'(wr_n - 1)] !== 8'h02 || wr_data[8'(wr_n - 1)] !== 32'h0200_0003) begin
            miscompares++;
            $display("FAIL enable_10m: done=%b last=%h=%h required 1 02=02000003",
                     done, wr_addr[8'(wr_n - 1)], wr_data[8'(wr_n - 1)]);
        end
        vectors++;
        if ({set_10, set_1000} !== 2'b10) begin
            miscompares++;
            $display("FAIL speed_10m: got s10/s1000=%b required 10", {set_10, set_1000});
        end
        link = 1'b0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!link_up) begin ok = 1; break; end
        end
        vectors++;
        if (!ok || done !== 1'b0) begin
            miscompares++;
            $display("FAIL linkdrop_status: link_up=%b done=%b required 0 0", link_up, done);
        end
        repeat (6) @(negedge clk);
        r81 = rd81_n;
        repeat (30) @(negedge clk);
        vectors++;
        if (wr_addr[8'(wr_n - 1)] !== 8'h02 || wr_data[8'(wr_n - 1)] !== 32'h0) begin
            miscompares++;
            $display("FAIL linkdrop_disable: got %h=%h required 02=00000000",
                     wr_addr[8'(wr_n - 1)], wr_data[8'(wr_n - 1)]);
        end
        vectors++;
        if (rd81_n - r81 < 3 || busy !== 1'b1 || set_10 !== 1'b1) begin
            miscompares++;
            $display("FAIL linkpoll_resume: polls=%0d busy=%b s10=%b required >=3 1 1",
                     rd81_n - r81, busy, set_10);
        end
        link = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (done) break;
        end
    endtask

    task automatic test_reset_mid();
        int  base;
        bit  ok;
        ws = 3; reg17 = 32'h0000_A800;
        bus_idle();
        pulse_start(48'h001C23174ACB);
        ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (avm_write && avm_address == 8'h04) begin ok = 1; break; end
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (!ok || {avm_read, avm_write, avm_address, avm_writedata} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_mid_bus: seen_mac1=%b rd=%b wr=%b addr=%h wd=%h required 1 0 0 0 0",
                     ok, avm_read, avm_write, avm_address, avm_writedata);
        end
        vectors++;
        if ({set_1000, set_10, busy, link_up, done, error} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_mid_status: got %b required 000000",
                     {set_1000, set_10, busy, link_up, done, error});
        end
        @(negedge clk);
        reset = 1'b0;
        ws = 0;
        repeat (2) @(negedge clk);
        base = wr_n;
        pulse_start(48'h001C23174ACB);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) break;
        end
        vectors++;
        if (!done || wr_n - base !== 6 || wr_data[8'(base)] !== 32'h2000 ||
            wr_data[8'(base + 5)] !== 32'h0B || set_1000 !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_restart: done=%b writes=%0d first=%h last=%h s1000=%b required 1 6 2000 b 1",
                     done, wr_n - base, wr_data[8'(base)], wr_data[8'(base + 5)], set_1000);
        end
    endtask

    initial begin
        test_reset();
        test_bringup_1000();
        test_waitstates();
        test_back_to_back();
        test_timeout();
        test_10m_linkdrop();
        test_reset_mid();
        vectors++;
        if (proto_err != 0) begin
            miscompares++;
            $display("FAIL rd_wr_exclusive: got %0d overlaps required 0", proto_err);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tse_mac_init_ctrl.md
TSE_MAC_INIT_CTRL -- requirements
Module: tse_mac_init_ctrl

Interface
REQ-001 SHALL have parameters: PHY_ADDR (default 5'd0, MDIO PHY address); POLL_INTERVAL (default 1_000_000, clk cycles between link re-checks); RST_TIMEOUT (default 1024, max SW-reset poll reads); FRM_LEN (default 1518, max frame length).
REQ-002 Port: clk_clk  in  1  single system clock; all logic on rising edge.
REQ-003 Port: reset_reset  in  1  reset, asynchronous, active-high.
REQ-004 Port: start  in  1  one-cycle pulse; starts or restarts the configuration sequence.
REQ-005 Port: mac_addr  in  48  station address; byte 0 in [47:40]; sampled on the start cycle.
REQ-006 Ports (Avalon-MM master to TSE CSR): avm_address out 8 (word address); avm_read out 1; avm_write out 1; avm_writedata out 32; avm_readdata in 32; avm_waitrequest in 1.
REQ-007 Ports: set_1000 out 1, set_10 out 1  drive MAC status set_1000/set_10.
REQ-008 Ports: busy out 1, link_up out 1, done out 1, error out 1  status.

Function
REQ-009 Avalon: address/read/write/writedata held stable while waitrequest=1; transfer completes on the first cycle with waitrequest=0; readdata captured that cycle; read and write never both 1; zero-wait-state slaves take exactly 1 cycle per transfer.
REQ-010 FSM states: IDLE, SWRST, SWRST_POLL, MAC0, MAC1, FRMLEN, MDIOADDR, LINK_POLL, SPEED, ENABLE, RUN, WAIT, ERR.
REQ-011 IDLE: on start -> SWRST; busy=1 in every state except IDLE, RUN, WAIT, ERR.
REQ-012 SWRST: write command_config (0x02) = 0x0000_2000 (SW_RESET) -> SWRST_POLL.
REQ-013 SWRST_POLL: read 0x02; bit13=0 -> MAC0; else re-read; after RST_TIMEOUT reads with bit13=1 -> ERR.
REQ-014 MAC0: write 0x03 = {mac_addr[23:16],mac_addr[31:24],mac_addr[39:32],mac_addr[47:40]}; MAC1: write 0x04 = {16'h0,mac_addr[7:0],mac_addr[15:8]}; FRMLEN: write 0x05 = FRM_LEN; MDIOADDR: write 0x0F = PHY_ADDR.
REQ-015 LINK_POLL: read 0x81 (PHY reg 1); bit2=1 -> SPEED; else re-read.
REQ-016 SPEED: read 0x91 (PHY reg 17); bit11=0 (unresolved) -> re-read; bits[15:14]=2'b10 -> 1000M, 2'b01 -> 100M, 2'b00 -> 10M, 2'b11 -> ERR.
REQ-017 ENABLE: write 0x02 = TX_ENA(bit0)|RX_ENA(bit1)|ETH_SPEED(bit3 if 1000M)|ENA_10(bit25 if 10M); on completion set set_1000/set_10 per speed, link_up=1, done=1 -> RUN.
REQ-018 RUN: load counter with POLL_INTERVAL-1 -> WAIT; WAIT decrements; at 0 read 0x81: bit2=1 -> RUN; bit2=0 -> link_up=0, done=0, write 0x02 = 0 (TX/RX disabled) then -> LINK_POLL.
REQ-019 ERR: error=1, busy=0, no Avalon activity; exit only via start or reset.
REQ-020 start while busy: ignored until the current Avalon transfer completes, then -> SWRST with error, done, link_up cleared; start in RUN/WAIT/ERR -> SWRST immediately.
REQ-021 set_1000 and set_10 SHALL never both be 1; both hold their value until the next ENABLE.

Reset
REQ-022 On reset_reset=1: state IDLE; avm_read=avm_write=0; avm_address=0; avm_writedata=0; set_1000=set_10=0; busy=link_up=done=error=0; counters 0.
REQ-023 Reset mid-transfer SHALL drop read/write asynchronously; no completion is assumed.

Structure
REQ-024 Shared package tse_ctrl_pkg SHALL hold register word offsets (0x02,0x03,0x04,0x05,0x0F,0x81,0x91), command_config bit positions, speed encoding, FSM state enum.
REQ-025 One sub-module tse_avm_xact SHALL implement the single-transfer Avalon handshake (req/wr/addr/wdata in; ack/rdata out); the FSM issues one request per state.

Verification
REQ-026 Zero-wait slave, SW_RESET clears on 2nd read, link up, reg17=0xA800, mac_addr=0x001C23174ACB -> writes 0x02=0x2000, 0x03=0x17231C00, 0x04=0x0000CB4A, 0x05=0x5EE, 0x0F=0, 0x02=0x0000000B; set_1000=1, done=1.
REQ-027 waitrequest high 3 cycles per transfer -> signals held stable 4 cycles each, same write sequence.
REQ-028 SW_RESET bit stuck 1 -> exactly RST_TIMEOUT reads of 0x02, then error=1, busy=0, bus idle.
REQ-029 reg17=0x0800 (10M) -> final write 0x0200_0003, set_10=1, set_1000=0; POLL_INTERVAL=16, link drops -> link_up=0, write 0x02=0, LINK_POLL reads resume.
REQ-030 Reset asserted during MAC1 write, and start pulsed mid-sequence -> outputs at reset values; after start, sequence restarts from SWRST.
